// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: taken decision, BHT training,
// and mispredict recovery (redirect plus two-cycle flush).
module branch_resolve_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_target_i,
  input  logic             ex_pred_taken_i,
  output logic             BrUn_o,
  input  logic             BrEq_i,
  input  logic             BrLt_i,
  input  logic [31:0]      if_pc_i,
  output logic             if_pred_taken_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IW = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    RECOVER,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic          legal;
  logic          taken;
  logic          resolve;
  logic          mispredict;
  logic [IW-1:0] ex_idx;
  logic [IW-1:0] if_idx;
  logic [1:0]    bht_q [BHT_ENTRIES];
  logic [31:0]   rpc_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] mcnt_q;

  assign BrUn_o = ex_funct3_i[1];
  assign ex_idx = ex_pc_i[IW+1:2];
  assign if_idx = if_pc_i[IW+1:2];

  // Map funct3 and comparator flags to a taken decision
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_funct3_i)
      3'b000: taken = BrEq_i;
      3'b001: taken = !BrEq_i;
      3'b100: taken = BrLt_i;
      3'b101: taken = !BrLt_i;
      3'b110: taken = BrLt_i;
      3'b111: taken = !BrLt_i;
      default: begin
        legal = 1'b0;
        taken = 1'b0;
      end
    endcase
  end

  assign resolve = ex_valid_i & ex_is_branch_i & legal
                 & !stall_i & (state_q == IDLE);
  assign mispredict = resolve & (taken != ex_pred_taken_i);

  // Recovery state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and recovery outputs
  always_comb begin
    state_d    = state_q;
    redirect_o = 1'b0;
    flush_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mispredict) state_d = RECOVER;
      end
      RECOVER: begin
        redirect_o = 1'b1;
        flush_o    = 1'b1;
        if (!stall_i) state_d = DRAIN;
      end
      DRAIN: begin
        flush_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the corrected fetch address on a mispredict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpc_q <= 32'd0;
    end else if (mispredict) begin
      rpc_q <= taken ? ex_target_i : ex_pc_i + 32'd4;
    end
  end

  assign redirect_pc_o = rpc_q;

  // Train the 2-bit saturating counters on resolve
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (resolve) begin
      if (taken && bht_q[ex_idx] != 2'b11) begin
        bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
      end else if (!taken && bht_q[ex_idx] != 2'b00) begin
        bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
    end
  end

  // Prediction reads the stored value; no write bypass
  assign if_pred_taken_o = bht_q[if_idx][1];

  // Saturating branch and mispredict statistics
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (resolve && bcnt_q != '1) begin
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (mispredict && mcnt_q != '1) begin
        mcnt_q <= mcnt_q + 1'b1;
      end
    end
  end

  assign branch_cnt_o  = bcnt_q;
  assign mispred_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: decode, BHT
// training, recovery sequencing, stall and reset.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        valid;
  logic        is_br;
  logic [2:0]  f3;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        pred_in;
  logic        br_un;
  logic        br_eq;
  logic        br_lt;
  logic [31:0] if_pc;
  logic        pred_out;
  logic        redir;
  logic [31:0] redir_pc;
  logic        flush;
  logic [15:0] bcnt;
  logic [15:0] mcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .BHT_ENTRIES(16),
    .CNT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .stall_i(stall),
    .ex_valid_i(valid),
    .ex_is_branch_i(is_br),
    .ex_funct3_i(f3),
    .ex_pc_i(pc),
    .ex_target_i(tgt),
    .ex_pred_taken_i(pred_in),
    .BrUn_o(br_un),
    .BrEq_i(br_eq),
    .BrLt_i(br_lt),
    .if_pc_i(if_pc),
    .if_pred_taken_o(pred_out),
    .redirect_o(redir),
    .redirect_pc_o(redir_pc),
    .flush_o(flush),
    .branch_cnt_o(bcnt),
    .mispred_cnt_o(mcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stall   = 1'b0;
    valid   = 1'b0;
    is_br   = 1'b0;
    f3      = 3'b000;
    pc      = 32'd0;
    tgt     = 32'd0;
    pred_in = 1'b0;
    br_eq   = 1'b0;
    br_lt   = 1'b0;
  endtask

  task automatic drive_br(input logic [2:0] fn,
                          input logic [31:0] p,
                          input logic [31:0] t,
                          input logic pr,
                          input logic eq,
                          input logic lt);
    valid   = 1'b1;
    is_br   = 1'b1;
    f3      = fn;
    pc      = p;
    tgt     = t;
    pred_in = pr;
    br_eq   = eq;
    br_lt   = lt;
  endtask

  task automatic test_por();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL por_out redir=%b flush=%b want 0 0", redir, flush);
    end
    checks++;
    if (bcnt !== 16'd0 || mcnt !== 16'd0 || redir_pc !== 32'd0) begin
      errors++;
      $display("FAIL por_state b=%0d m=%0d pc=%h want 0 0 0", bcnt, mcnt, redir_pc);
    end
  endtask

  task automatic test_brun();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      f3 = v;
      #1;
      checks++;
      if (br_un !== v[1]) begin
        errors++;
        $display("FAIL brun f3=%b got %b want %b", v, br_un, v[1]);
      end
    end
    f3 = 3'b000;
  endtask

  task automatic test_beq();
    drive_br(3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
    #1;
    checks++;
    if (redir !== 1'b1 || flush !== 1'b1 || redir_pc !== 32'h140) begin
      errors++;
      $display("FAIL beq_rec redir=%b flush=%b pc=%h want 1 1 140", redir, flush, redir_pc);
    end
    checks++;
    if (bcnt !== 16'd1 || mcnt !== 16'd1) begin
      errors++;
      $display("FAIL beq_cnt b=%0d m=%0d want 1 1", bcnt, mcnt);
    end
    step();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL beq_drain redir=%b flush=%b want 0 1", redir, flush);
    end
    step();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL beq_idle redir=%b flush=%b want 0 0", redir, flush);
    end
  endtask

  task automatic test_bltu();
    drive_br(3'b110, 32'h104, 32'h180, 1'b0, 1'b0, 1'b0);
    if_pc = 32'h104;
    #1;
    checks++;
    if (br_un !== 1'b1 || pred_out !== 1'b0) begin
      errors++;
      $display("FAIL bltu_pre brun=%b pred=%b want 1 0", br_un, pred_out);
    end
    step();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL bltu_redir redir=%b flush=%b want 0 0", redir, flush);
    end
    checks++;
    if (bcnt !== 16'd2 || mcnt !== 16'd1) begin
      errors++;
      $display("FAIL bltu_cnt b=%0d m=%0d want 2 1", bcnt, mcnt);
    end
    drive_br(3'b110, 32'h104, 32'h180, 1'b1, 1'b0, 1'b1);
    step();
    idle_in();
    #1;
    checks++;
    if (pred_out !== 1'b0 || redir !== 1'b0 || bcnt !== 16'd3) begin
      errors++;
      $display("FAIL bltu_ctr pred=%b redir=%b b=%0d want 0 0 3", pred_out, redir, bcnt);
    end
  endtask

  task automatic test_bne_recover();
    drive_br(3'b001, 32'h1FC, 32'h400, 1'b1, 1'b1, 1'b0);
    step();
    drive_br(3'b000, 32'h300, 32'h500, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (redir !== 1'b1 || redir_pc !== 32'h200) begin
      errors++;
      $display("FAIL bne_pc redir=%b pc=%h want 1 200", redir, redir_pc);
    end
    checks++;
    if (bcnt !== 16'd4 || mcnt !== 16'd2) begin
      errors++;
      $display("FAIL bne_cnt b=%0d m=%0d want 4 2", bcnt, mcnt);
    end
    step();
    checks++;
    if (bcnt !== 16'd4 || mcnt !== 16'd2 || flush !== 1'b1) begin
      errors++;
      $display("FAIL bne_drain b=%0d m=%0d flush=%b want 4 2 1", bcnt, mcnt, flush);
    end
    step();
    idle_in();
    #1;
    checks++;
    if (bcnt !== 16'd4 || mcnt !== 16'd2 || redir !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL bne_wrongpath b=%0d m=%0d r=%b f=%b want 4 2 0 0", bcnt, mcnt, redir, flush);
    end
    checks++;
    if (redir_pc !== 32'h200) begin
      errors++;
      $display("FAIL bne_pchold pc=%h want 200", redir_pc);
    end
  endtask

  task automatic test_train();
    if_pc = 32'h20;
    drive_br(3'b000, 32'h20, 32'h60, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (pred_out !== 1'b0) begin
      errors++;
      $display("FAIL train_same got %b want 0", pred_out);
    end
    step();
    checks++;
    if (pred_out !== 1'b1) begin
      errors++;
      $display("FAIL train_next got %b want 1", pred_out);
    end
    step();
    step();
    step();
    drive_br(3'b000, 32'h20, 32'h60, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (pred_out !== 1'b1 || bcnt !== 16'd8) begin
      errors++;
      $display("FAIL train_sat pred=%b b=%0d want 1 8", pred_out, bcnt);
    end
    step();
    checks++;
    if (pred_out !== 1'b1) begin
      errors++;
      $display("FAIL train_dec1 got %b want 1", pred_out);
    end
    step();
    idle_in();
    #1;
    checks++;
    if (pred_out !== 1'b0 || bcnt !== 16'd10 || mcnt !== 16'd2) begin
      errors++;
      $display("FAIL train_dec2 pred=%b b=%0d m=%0d want 0 10 2", pred_out, bcnt, mcnt);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    drive_br(3'b000, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0);
    step();
    checks++;
    if (redir !== 1'b0 || bcnt !== 16'd10 || mcnt !== 16'd2) begin
      errors++;
      $display("FAIL stall_ex redir=%b b=%0d m=%0d want 0 10 2", redir, bcnt, mcnt);
    end
    stall = 1'b0;
    step();
    idle_in();
    stall = 1'b1;
    step();
    step();
    checks++;
    if (redir !== 1'b1 || flush !== 1'b1 || redir_pc !== 32'h80) begin
      errors++;
      $display("FAIL stall_hold r=%b f=%b pc=%h want 1 1 80", redir, flush, redir_pc);
    end
    stall = 1'b0;
    step();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain r=%b f=%b want 0 1", redir, flush);
    end
    step();
    checks++;
    if (flush !== 1'b0 || bcnt !== 16'd11 || mcnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_done f=%b b=%0d m=%0d want 0 11 3", flush, bcnt, mcnt);
    end
    if_pc = 32'h100;
    drive_br(3'b010, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    #1;
    checks++;
    if (redir !== 1'b0 || bcnt !== 16'd11 || mcnt !== 16'd3 || pred_out !== 1'b1) begin
      errors++;
      $display("FAIL illegal r=%b b=%0d m=%0d pred=%b want 0 11 3 1", redir, bcnt, mcnt, pred_out);
    end
  endtask

  task automatic test_reset();
    drive_br(3'b000, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    checks++;
    if (redir !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup redir=%b want 1", redir);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (redir !== 1'b0 || flush !== 1'b0 || redir_pc !== 32'd0) begin
      errors++;
      $display("FAIL rst_async r=%b f=%b pc=%h want 0 0 0", redir, flush, redir_pc);
    end
    checks++;
    if (bcnt !== 16'd0 || mcnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt b=%0d m=%0d want 0 0", bcnt, mcnt);
    end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      checks++;
      if (pred_out !== 1'b0) begin
        errors++;
        $display("FAIL rst_bht idx=%0d got %b want 0", i, pred_out);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (redir !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rst_after r=%b f=%b want 0 0", redir, flush);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    if_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_por();
    rst_n = 1'b1;
    step();
    test_brun();
    test_beq();
    test_bltu();
    test_bne_recover();
    test_train();
    test_stall();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
